// File: rtl/serial_pkg.sv
// serial_pkg
//   Shared definitions for the serial bit source that feeds the Mealy
//   sequence-detector datapath.
//   Contents:
//     state_t            - FSM state encoding (IDLE=2'b00, SHIFT=2'b01;
//                          the unused codes are treated as IDLE)
//     SERIAL_WIDTH_DEF   - default word width
//     state_is_shift()   - decode helper, true only for the SHIFT code
package serial_pkg;

  localparam int SERIAL_WIDTH_DEF = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01
  } state_t;

  // Anything other than the SHIFT code is treated as IDLE, so a corrupted
  // state register can never leave the serial line driving data.
  function automatic logic state_is_shift(input state_t s);
    return (s == SHIFT);
  endfunction

endpackage

// File: rtl/serial_hold_reg.sv
// serial_hold_reg
//   One-entry holding register with a full flag. The serial source uses it
//   to park the next word while the current word is still shifting out, so
//   back-to-back words leave the serial line without a gap.
//   Ports:
//     clock      in   rising-edge clock
//     reset      in   synchronous active-high reset, empties the entry
//     load       in   capture load_data and mark the entry full
//     load_data  in   WIDTH-bit word to park
//     take       in   consumer has taken the parked word, mark empty
//     full       out  entry holds a valid word
//     data       out  parked word
//   The owner must never assert load and take in the same cycle; if it does,
//   load wins so no offered word is lost.
module serial_hold_reg #(
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             take,
  output logic             full,
  output logic [WIDTH-1:0] data
);

  // Full flag and payload are updated together so data is only meaningful
  // while full is set.
  always_ff @(posedge clock) begin
    if (reset) begin
      full <= 1'b0;
      data <= '0;
    end else if (load) begin
      full <= 1'b1;
      data <= load_data;
    end else if (take) begin
      full <= 1'b0;
    end
  end

endmodule

// File: rtl/serial_bit_source.sv
// serial_bit_source
//   Parallel-to-serial source for the sequence detector. Accepts WIDTH-bit
//   words over a valid/ready handshake and drives them MSB-first, one bit
//   per clock, on x. While no data bit is being shifted x is held at 0.
//   Ports:
//     clock       in   rising-edge clock
//     reset       in   synchronous active-high reset (aborts any partial word)
//     data_in     in   word to serialize, sampled only on the accept edge
//     load_valid  in   data_in is valid
//     load_ready  out  a word can be accepted this cycle
//     x           out  serial bit, 0 when bit_valid is 0
//     bit_valid   out  x carries a data bit this cycle
//     word_done   out  one-cycle pulse alongside the LSB of each word
//     busy        out  FSM is in SHIFT
//   Build option:
//     SERIAL_SOURCE_PREFETCH_EN - adds a one-entry hold register so the next
//     word can be accepted while shifting, giving gapless back-to-back words.
//     Without it a word can only be accepted from IDLE, which inserts one
//     idle cycle between words.
//   All outputs decode registered state only; there is no combinational path
//   from any input to any output.
module serial_bit_source
  import serial_pkg::*;
#(
  parameter int WIDTH = SERIAL_WIDTH_DEF
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_in,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             x,
  output logic             bit_valid,
  output logic             word_done,
  output logic             busy
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  state_t           state;
  logic [WIDTH-1:0] shreg;
  logic [CW-1:0]    cnt;

  logic in_shift;
  logic last_bit;
  logic accept;

  assign in_shift = state_is_shift(state);
  assign last_bit = in_shift && (cnt == '0);

  // load_valid is ignored during reset so nothing is latched on the reset edge.
  assign accept = load_valid && load_ready && !reset;

`ifdef SERIAL_SOURCE_PREFETCH_EN
  logic             hold_full;
  logic [WIDTH-1:0] hold_data;
  logic             hold_load;
  logic             hold_take;

  // A word offered mid-word is parked; on the last bit with nothing parked
  // it goes straight into the shift register instead.
  assign load_ready = !hold_full;
  assign hold_load  = accept && in_shift && !last_bit;
  assign hold_take  = last_bit && hold_full;

  serial_hold_reg #(
    .WIDTH(WIDTH)
  ) u_hold (
    .clock     (clock),
    .reset     (reset),
    .load      (hold_load),
    .load_data (data_in),
    .take      (hold_take),
    .full      (hold_full),
    .data      (hold_data)
  );
`else
  assign load_ready = !in_shift;
`endif

  // FSM, bit counter and shift register. The counter holds the number of
  // bits still to come after the one currently on x, so cnt==0 marks the LSB.
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      shreg <= '0;
      cnt   <= '0;
    end else begin
      case (state)
        SHIFT: begin
          shreg <= shreg << 1;
          cnt   <= cnt - CNT_ONE;
          if (cnt == '0) begin
`ifdef SERIAL_SOURCE_PREFETCH_EN
            if (hold_full) begin
              shreg <= hold_data;
              cnt   <= CNT_LAST;
            end else if (accept) begin
              shreg <= data_in;
              cnt   <= CNT_LAST;
            end else begin
              state <= IDLE;
              cnt   <= '0;
            end
`else
            state <= IDLE;
            cnt   <= '0;
`endif
          end
        end
        default: begin
          // IDLE and any illegal code: wait for a word, recover to IDLE.
          if (accept) begin
            state <= SHIFT;
            shreg <= data_in;
            cnt   <= CNT_LAST;
          end else begin
            state <= IDLE;
          end
        end
      endcase
    end
  end

  assign busy      = in_shift;
  assign bit_valid = in_shift;
  assign x         = in_shift && shreg[WIDTH-1];
  assign word_done = last_bit;

endmodule

// File: tb/tb_serial_bit_source.sv
// tb_serial_bit_source
//   Directed, self-checking bench for serial_bit_source (WIDTH=8). Expected
//   streams are hand-written constants; the ones that differ with the
//   SERIAL_SOURCE_PREFETCH_EN build option are selected with the same macro.
//   Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_serial_bit_source;

  localparam int W = 8;

  logic         clock;
  logic         reset;
  logic [W-1:0] data_in;
  logic         load_valid;
  logic         load_ready;
  logic         x;
  logic         bit_valid;
  logic         word_done;
  logic         busy;

  int checks   = 0;
  int failures = 0;

  logic x_log     [0:31];
  logic valid_log [0:31];
  logic done_log  [0:31];
  logic ready_log [0:31];

  serial_bit_source #(.WIDTH(W)) dut (
    .clock      (clock),
    .reset      (reset),
    .data_in    (data_in),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .x          (x),
    .bit_valid  (bit_valid),
    .word_done  (word_done),
    .busy       (busy)
  );

  // 10-unit clock.
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Hard stop in case anything stalls.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Offers up to three words back to back, advancing to the next word after
  // each handshake, and logs n_samples output samples taken after each edge.
  // Must be called with the DUT idle.
  task automatic run_words(input logic [W-1:0] w0, input logic [W-1:0] w1,
                           input logic [W-1:0] w2, input int n_words,
                           input int n_samples);
    logic [W-1:0] words [0:2];
    int idx;
    logic acc;
    words[0] = w0;
    words[1] = w1;
    words[2] = w2;
    idx = 0;
    data_in = words[0];
    load_valid = 1'b1;
    for (int i = 0; i < n_samples; i++) begin
      acc = load_valid && load_ready;
      tick();
      if (acc) begin
        idx++;
        if (idx < n_words) data_in = words[idx];
        else load_valid = 1'b0;
      end
      x_log[i]     = x;
      valid_log[i] = bit_valid;
      done_log[i]  = word_done;
      ready_log[i] = load_ready;
    end
    load_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    load_valid = 1'b0;
    data_in = '0;
    tick();
    tick();
    checks++; if (x !== 1'b0) begin failures++; $display("[TB] FAIL reset x: got %0b expected 0", x); end
    checks++; if (bit_valid !== 1'b0) begin failures++; $display("[TB] FAIL reset bit_valid: got %0b expected 0", bit_valid); end
    checks++; if (word_done !== 1'b0) begin failures++; $display("[TB] FAIL reset word_done: got %0b expected 0", word_done); end
    checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL reset busy: got %0b expected 0", busy); end
    checks++; if (load_ready !== 1'b1) begin failures++; $display("[TB] FAIL reset load_ready: got %0b expected 1", load_ready); end
    reset = 1'b0;
  endtask

  task automatic test_idle();
    for (int i = 0; i < 20; i++) begin
      tick();
      checks++; if (x !== 1'b0) begin failures++; $display("[TB] FAIL idle x[%0d]: got %0b expected 0", i, x); end
      checks++; if (bit_valid !== 1'b0) begin failures++; $display("[TB] FAIL idle bit_valid[%0d]: got %0b expected 0", i, bit_valid); end
      checks++; if (load_ready !== 1'b1) begin failures++; $display("[TB] FAIL idle load_ready[%0d]: got %0b expected 1", i, load_ready); end
    end
  endtask

  // 8'b1001_0000, followed by two idle samples. A 1001 detector on x fires
  // on the fourth data bit only.
  task automatic test_single_word();
    logic [9:0] exp_x;
    logic [9:0] exp_v;
    logic [9:0] exp_d;
    logic [3:0] hist;
    logic z;
    exp_x = 10'b1001_0000_00;
    exp_v = 10'b1111_1111_00;
    exp_d = 10'b0000_0001_00;
    hist = 4'b0000;
    run_words(8'b1001_0000, 8'h00, 8'h00, 1, 10);
    for (int i = 0; i < 10; i++) begin
      checks++; if (x_log[i] !== exp_x[9-i]) begin failures++; $display("[TB] FAIL single x[%0d]: got %0b expected %0b", i, x_log[i], exp_x[9-i]); end
      checks++; if (valid_log[i] !== exp_v[9-i]) begin failures++; $display("[TB] FAIL single bit_valid[%0d]: got %0b expected %0b", i, valid_log[i], exp_v[9-i]); end
      checks++; if (done_log[i] !== exp_d[9-i]) begin failures++; $display("[TB] FAIL single word_done[%0d]: got %0b expected %0b", i, done_log[i], exp_d[9-i]); end
      hist = {hist[2:0], x_log[i] & valid_log[i]};
      z = (hist == 4'b1001);
      checks++; if (z !== (i == 3)) begin failures++; $display("[TB] FAIL single detector_z[%0d]: got %0b expected %0b", i, z, (i == 3)); end
    end
    checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL single busy_after: got %0b expected 0", busy); end
  endtask

  // 8'hA5 then 8'h3C with load_valid held: one gap cycle without prefetch,
  // contiguous with prefetch.
  task automatic test_back_to_back();
    logic [16:0] exp_x;
    logic [16:0] exp_v;
    logic [16:0] exp_d;
`ifdef SERIAL_SOURCE_PREFETCH_EN
    exp_x = 17'b10100101_00111100_0;
    exp_v = 17'b11111111_11111111_0;
    exp_d = 17'b00000001_00000001_0;
`else
    exp_x = 17'b10100101_0_00111100;
    exp_v = 17'b11111111_0_11111111;
    exp_d = 17'b00000001_0_00000001;
`endif
    run_words(8'hA5, 8'h3C, 8'h00, 2, 17);
    for (int i = 0; i < 17; i++) begin
      checks++; if (x_log[i] !== exp_x[16-i]) begin failures++; $display("[TB] FAIL b2b x[%0d]: got %0b expected %0b", i, x_log[i], exp_x[16-i]); end
      checks++; if (valid_log[i] !== exp_v[16-i]) begin failures++; $display("[TB] FAIL b2b bit_valid[%0d]: got %0b expected %0b", i, valid_log[i], exp_v[16-i]); end
      checks++; if (done_log[i] !== exp_d[16-i]) begin failures++; $display("[TB] FAIL b2b word_done[%0d]: got %0b expected %0b", i, done_log[i], exp_d[16-i]); end
    end
    tick();
  endtask

  // Three words 8'hC3, 8'h5A, 8'hF0 offered continuously; checks the ready
  // pattern and that the stream holds each word exactly once, in order.
  task automatic test_backpressure();
    logic [26:0] exp_x;
    logic [26:0] exp_v;
    logic [26:0] exp_d;
    logic [26:0] exp_r;
`ifdef SERIAL_SOURCE_PREFETCH_EN
    exp_x = 27'b11000011_01011010_11110000_000;
    exp_v = 27'b11111111_11111111_11111111_000;
    exp_d = 27'b00000001_00000001_00000001_000;
    exp_r = 27'b10000000_10000000_11111111_111;
`else
    exp_x = 27'b11000011_0_01011010_0_11110000_0;
    exp_v = 27'b11111111_0_11111111_0_11111111_0;
    exp_d = 27'b00000001_0_00000001_0_00000001_0;
    exp_r = 27'b00000000_1_00000000_1_00000000_1;
`endif
    run_words(8'hC3, 8'h5A, 8'hF0, 3, 27);
    for (int i = 0; i < 27; i++) begin
      checks++; if (x_log[i] !== exp_x[26-i]) begin failures++; $display("[TB] FAIL bp x[%0d]: got %0b expected %0b", i, x_log[i], exp_x[26-i]); end
      checks++; if (valid_log[i] !== exp_v[26-i]) begin failures++; $display("[TB] FAIL bp bit_valid[%0d]: got %0b expected %0b", i, valid_log[i], exp_v[26-i]); end
      checks++; if (done_log[i] !== exp_d[26-i]) begin failures++; $display("[TB] FAIL bp word_done[%0d]: got %0b expected %0b", i, done_log[i], exp_d[26-i]); end
      checks++; if (ready_log[i] !== exp_r[26-i]) begin failures++; $display("[TB] FAIL bp load_ready[%0d]: got %0b expected %0b", i, ready_log[i], exp_r[26-i]); end
    end
  endtask

  // Reset after three bits of 8'hFF, with load_valid high during reset,
  // then 8'h81 must come out cleanly from its MSB.
  task automatic test_reset_mid_word();
    logic [8:0] exp_x;
    exp_x = 9'b1000_0001_0;
    run_words(8'hFF, 8'h00, 8'h00, 1, 3);
    for (int i = 0; i < 3; i++) begin
      checks++; if (x_log[i] !== 1'b1) begin failures++; $display("[TB] FAIL midrst pre_x[%0d]: got %0b expected 1", i, x_log[i]); end
    end
    reset = 1'b1;
    load_valid = 1'b1;
    data_in = 8'h55;
    tick();
    reset = 1'b0;
    load_valid = 1'b0;
    checks++; if (x !== 1'b0) begin failures++; $display("[TB] FAIL midrst x: got %0b expected 0", x); end
    checks++; if (bit_valid !== 1'b0) begin failures++; $display("[TB] FAIL midrst bit_valid: got %0b expected 0", bit_valid); end
    checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL midrst busy: got %0b expected 0", busy); end
    checks++; if (load_ready !== 1'b1) begin failures++; $display("[TB] FAIL midrst load_ready: got %0b expected 1", load_ready); end
    tick();
    checks++; if (bit_valid !== 1'b0) begin failures++; $display("[TB] FAIL midrst still_idle: got %0b expected 0", bit_valid); end
    run_words(8'h81, 8'h00, 8'h00, 1, 9);
    for (int i = 0; i < 9; i++) begin
      checks++; if (x_log[i] !== exp_x[8-i]) begin failures++; $display("[TB] FAIL midrst new_x[%0d]: got %0b expected %0b", i, x_log[i], exp_x[8-i]); end
      checks++; if (valid_log[i] !== (i < 8)) begin failures++; $display("[TB] FAIL midrst new_valid[%0d]: got %0b expected %0b", i, valid_log[i], (i < 8)); end
    end
  endtask

`ifndef SERIAL_SOURCE_PREFETCH_EN
  // Without prefetch, a load_valid pulse mid-word is not accepted: 8'h96
  // finishes unchanged and no second word follows.
  task automatic test_ignored_load();
    logic [10:0] exp_x;
    logic [10:0] exp_v;
    exp_x = 11'b1001_0110_000;
    exp_v = 11'b1111_1111_000;
    data_in = 8'h96;
    load_valid = 1'b1;
    tick();
    load_valid = 1'b0;
    data_in = 8'hFF;
    for (int i = 0; i < 11; i++) begin
      checks++; if (x !== exp_x[10-i]) begin failures++; $display("[TB] FAIL ignload x[%0d]: got %0b expected %0b", i, x, exp_x[10-i]); end
      checks++; if (bit_valid !== exp_v[10-i]) begin failures++; $display("[TB] FAIL ignload bit_valid[%0d]: got %0b expected %0b", i, bit_valid, exp_v[10-i]); end
      load_valid = (i == 2);
      tick();
    end
    load_valid = 1'b0;
  endtask
`endif

  initial begin
    reset = 1'b1;
    load_valid = 1'b0;
    data_in = '0;
    test_reset();
    test_idle();
    test_single_word();
    test_back_to_back();
    test_backpressure();
    test_reset_mid_word();
`ifndef SERIAL_SOURCE_PREFETCH_EN
    test_ignored_load();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
